fp_add_arbiter: RTL
===================

Name: fp_add_arbiter

Overview:
- Round-robin scheduler that shares one fully pipelined, handshake-free FP32 adder (ahfp_add_multi class, fixed latency ADD_LAT) between N requesters.
- Accepts at most one operand pair per cycle via valid/ready, registers it into the adder, and tracks the requester ID through a tag pipeline matched to adder latency.
- Returns each result to its originator as a one-cycle response pulse.
- Sits between compute clients and the adder instance, which is external to this block.

Parameters:
- N, 4, number of requesters (2..8)
- ADD_LAT, 7, adder latency: clock edges from the adder sampling dataa/datab to the matching result appearing on add_result
- IDW, $clog2(N), requester ID width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N  per-requester operand-pair valid
- req_a  in  N*32  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  N*32  operand B; same packing as req_a
- req_ready  out  N  one-hot grant; transfer happens when req_valid[i]&req_ready[i]
- add_dataa  out  32  to adder dataa (registered)
- add_datab  out  32  to adder datab (registered)
- add_result  in  32  from adder result
- rsp_valid  out  N  one-cycle pulse; result for requester i is on rsp_data
- rsp_data  out  32  result word (registered)
- inflight  out  IDW+4  operations issued but not yet responded
- busy  out  1  inflight!=0 or any req_valid

Behaviour:
- Reset (async, immediate) clears everything:
  - req_ready=0, rsp_valid=0, rsp_data=0, add_dataa=0, add_datab=0, inflight=0, busy=0.
  - RR pointer = N-1, so requester 0 has first priority.
  - All tag-pipe valid bits cleared.
- Arbitration (combinational):
  - Grant goes to the first requester with req_valid set, searching from ptr+1 modulo N.
  - req_ready is one-hot on that requester, or all-zero if none is valid.
  - req_ready must never be asserted for a requester whose req_valid is low.
  - During rst, req_ready=0.
- Handshake:
  - A transfer completes in any cycle where req_valid[g]&req_ready[g].
  - ptr <= g only on transfer; ptr holds when idle.
  - Requesters hold req_a/req_b stable while valid and unaccepted.
- Issue stage:
  - On transfer at cycle t: add_dataa/add_datab <= req_a/req_b slice of g at edge t+1, and tag stage 0 <= {1, g}.
  - No transfer: operands <= 0 and tag valid <= 0. The adder is free-running; those results are discarded.
- Tag pipeline:
  - ADD_LAT+1 stages of {valid, id}, shifted every cycle.
  - The stage aligned with add_result holds the tag of the operands sampled ADD_LAT edges earlier.
- Response:
  - When the aligned tag is valid: rsp_valid[id] <= 1 and rsp_data <= add_result; otherwise rsp_valid <= 0.
  - rsp_data holds its last value when idle.
  - No backpressure on responses; requesters must always accept.
- Latency:
  - Handshake at cycle t gives rsp_valid in cycle t+ADD_LAT+2 (9 by default).
  - Throughput is 1 op/cycle aggregate.
  - Responses return in issue order.
- inflight:
  - +1 on transfer, -1 on response pulse, net 0 when both occur in the same cycle.
  - Maximum value is ADD_LAT+2.
- Boundary conditions:
  - A single active requester is granted every cycle (back-to-back).
  - All N active: grants rotate strictly 0,1,...,N-1,0.
  - A requester dropping req_valid before acceptance simply loses arbitration; no state is kept.
  - Reset mid-operation: in-flight tags are cleared, no responses are emitted for them, and adder pipeline contents are ignored. The adder itself has no reset.
- Adder sign caveat: the adder takes the sign from dataa only. The block passes operands unmodified, and sign handling is the requesters' concern.

Decomposition:
- Shared package fp_add_pkg:
  - FP_W=32
  - ADD_LAT=7 constant, with the adder latency documented beside it
  - typedef tag_t {logic vld; logic [IDW-1:0] id;}
  - FP constants ONE=32'h3F800000, TWO=32'h40000000
- One natural sub-module: rr_arbiter (N-bit request in, one-hot grant out, advance input, pointer register). It is reusable for other shared datapaths.
- The tag delay line stays inline.

Test Plan:
- Single request: requester 0 sends a=0x3F800000, b=0x40000000 at cycle t → req_ready[0]=1 at t; rsp_valid[0]=1 at t+9 with rsp_data=0x40400000; inflight 1 during t+1..t+9, then 0.
- Rotation: all four requesters hold valid, each with a distinct pair (requester i: a=i+1.0, b=1.0), for 8 cycles → grants in order 0,1,2,3,0,1,2,3; responses arrive in the same order, 9 cycles after each grant, with correct sums (e.g. 0x40000000 for requester 0).
- Back-to-back single requester: requester 2 valid for 10 consecutive cycles → ready every cycle; 10 consecutive rsp_valid[2] pulses; inflight peaks at 9.
- Pointer fairness: requesters 1 and 3 valid continuously after a grant to 1 → next grant 3, then 1; requester 1 is never granted twice while 3 is waiting.
- Reset mid-flight: issue 3 ops, assert rst 4 cycles later for 1 cycle → all outputs 0 immediately; no rsp_valid in the following 12 cycles; next request granted to requester 0 first.
- Idle: no req_valid for 20 cycles → rsp_valid stays 0, add_dataa=add_datab=0, busy=0.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP32 adder sharing logic.
package fp_add_pkg;
  localparam int FP_W = 32;
  // External adder latency: clock edges from sampling dataa/datab to the result on add_result.
  localparam int ADD_LAT = 7;
  // Tag ID width sized for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               vld;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  localparam logic [FP_W-1:0] ONE = 32'h3F800000;
  localparam logic [FP_W-1:0] TWO = 32'h40000000;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr+1, pointer moves to the winner on advance.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);
  logic [IDW-1:0] ptr;

  // Scan from the farthest candidate to the nearest so the nearest valid request wins.
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant    = N'(1) << idx;
        grant_id = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(N - 1);
    end else if (advance) begin
      ptr <= grant_id;
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency FP32 adder among N requesters; tags track each issue back to its owner.
module fp_add_arbiter #(
  parameter int N       = 4,
  parameter int ADD_LAT = fp_add_pkg::ADD_LAT,
  parameter int IDW     = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                req_valid,
  input  logic [N*fp_add_pkg::FP_W-1:0] req_a,
  input  logic [N*fp_add_pkg::FP_W-1:0] req_b,
  output logic [N-1:0]                req_ready,
  output logic [fp_add_pkg::FP_W-1:0] add_dataa,
  output logic [fp_add_pkg::FP_W-1:0] add_datab,
  input  logic [fp_add_pkg::FP_W-1:0] add_result,
  output logic [N-1:0]                rsp_valid,
  output logic [fp_add_pkg::FP_W-1:0] rsp_data,
  output logic [IDW+3:0]              inflight,
  output logic                        busy
);
  import fp_add_pkg::*;

  localparam int CW = IDW + 4;

  // Handshake: a pair moves when req_valid[i] & req_ready[i]; ready is one-hot and only on a valid requester.
  logic [N-1:0]   grant;
  logic [IDW-1:0] gid;
  logic           xfer;
  tag_t           tag_q [ADD_LAT+1];
  tag_t           out_tag;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (gid)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = !rst && ((inflight != '0) || (|req_valid));
  assign out_tag   = tag_q[ADD_LAT];

  // Idle cycles feed zeros; the adder runs freely and those results carry an invalid tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_dataa <= '0;
      add_datab <= '0;
      for (int k = 0; k <= ADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      if (xfer) begin
        add_dataa <= req_a[int'(gid)*FP_W +: FP_W];
        add_datab <= req_b[int'(gid)*FP_W +: FP_W];
        tag_q[0]  <= '{vld: 1'b1, id: TAG_IDW'(gid)};
      end else begin
        add_dataa <= '0;
        add_datab <= '0;
        tag_q[0]  <= '0;
      end
      for (int k = 1; k <= ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= out_tag.vld ? (N'(1) << out_tag.id) : '0;
      if (out_tag.vld) rsp_data <= add_result;
    end
  end

  // An issue and a response in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({xfer, |rsp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end
endmodule
